// File: rtl/pipe_pkg.sv
// Shared types for the skid pipeline register: state encoding and occupancy width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_data_reg.sv
// len-bit data register; synchronous clear wins over load enable.
module pipe_data_reg #(
  parameter int len = 32
) (
  input  logic           i_clk,
  input  logic           i_clr,
  input  logic           i_en,
  input  logic [len-1:0] i_d,
  output logic [len-1:0] o_q
);

  logic [len-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/skid_pipe_reg.sv
// Valid/ready pipeline register with one-entry skid buffer, flush and saturating stall counter.
// All outputs are registers or state decode, so no combinational path crosses the block.
module skid_pipe_reg
  import pipe_pkg::*;
#(
  parameter int len     = 32,
  parameter int cnt_len = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [len-1:0]     i_in_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [len-1:0]     o_out_data,
  output logic [OCC_W-1:0]   o_occupancy,
  output logic [cnt_len-1:0] o_stall_cnt
);

  localparam logic [cnt_len-1:0] STALL_MAX = '1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [cnt_len-1:0] r_stall_cnt;

  logic           w_in_ready;
  logic           w_out_valid;
  logic           w_accept;
  logic           w_fire;
  logic           w_clr;
  logic           w_main_en;
  logic           w_skid_en;
  logic [len-1:0] w_main_d;
  logic [len-1:0] w_main_q;
  logic [len-1:0] w_skid_q;

  assign w_in_ready  = (r_state != TWO);
  assign w_out_valid = (r_state != EMPTY);
  assign w_accept    = i_in_valid & w_in_ready;
  assign w_fire      = w_out_valid & i_out_ready;
  assign w_clr       = i_rst | i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= EMPTY;
    end else if (i_flush) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    w_skid_en   = 1'b0;
    w_main_d    = i_in_data;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_main_en   = 1'b1;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_accept && w_fire) begin
          w_main_en = 1'b1;
        end else if (w_accept) begin
          // Downstream stalled: park the new word so in_ready stays registered.
          w_skid_en   = 1'b1;
          w_state_nxt = TWO;
        end else if (w_fire) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_fire) begin
          w_main_en   = 1'b1;
          w_main_d    = w_skid_q;
          w_state_nxt = ONE;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  pipe_data_reg #(.len(len)) u_main (
    .i_clk (i_clk),
    .i_clr (w_clr),
    .i_en  (w_main_en),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  pipe_data_reg #(.len(len)) u_skid (
    .i_clk (i_clk),
    .i_clr (w_clr),
    .i_en  (w_skid_en),
    .i_d   (i_in_data),
    .o_q   (w_skid_q)
  );

  // Counts refused offers; flush deliberately leaves it alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (i_in_valid && !w_in_ready && (r_stall_cnt != STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + cnt_len'(1);
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_out_data  = w_main_q;
  assign o_occupancy = OCC_W'(r_state);
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: doc/skid_pipe_reg.md
# skid_pipe_reg

Parametrised pipeline register with a valid/ready handshake and a one-entry skid buffer, the successor to the plain load-enable register used between datapath stages. It sustains one transfer per cycle and breaks every combinational path between upstream and downstream, including the ready path. It adds a synchronous flush and a saturating stall counter. It sits between pipeline stages and between the datapath and memory interfaces of the processor.

## Interface
- len, 32, data width in bits (≥1)
- cnt_len, 16, stall counter width in bits (≥1)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous discard of all held data
- in_valid  input  1  upstream data valid
- in_ready  output  1  block can accept this cycle
- in_data  input  len  upstream data
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts this cycle
- out_data  output  len  downstream data
- occupancy  output  2  number of held entries, 0..2
- stall_cnt  output  cnt_len  saturating count of back-pressured cycles

## Operation
- One clock domain. Reset is synchronous and active-high.
- Accept = in_valid & in_ready. Fire = out_valid & out_ready.
- State machine:
  - EMPTY: occupancy 0.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- EMPTY: on accept, main <= in_data and go to ONE. Otherwise stay.
- ONE:
  - Accept & fire: main <= in_data, stay in ONE.
  - Accept & !fire: skid <= in_data, go to TWO.
  - !accept & fire: go to EMPTY.
  - Otherwise hold.
- TWO: on fire, main <= skid, go to ONE. Otherwise hold. No accept is possible because in_ready = 0.
- in_ready = (state != TWO). It depends only on state.
- out_valid = (state != EMPTY). out_data = main.
- Data is delivered in order. No entry is dropped or duplicated unless flush is asserted.
- stall_cnt increments each cycle in_valid & !in_ready holds. It saturates at 2^cnt_len − 1 and never wraps.
- flush:
  - Next state is EMPTY.
  - main and skid are cleared to 0.
  - A concurrent accept is discarded. A concurrent fire still counts as delivered downstream.
  - stall_cnt is unaffected.
- Priority: rst > flush > handshake.
- rst clears the state to EMPTY and clears main, skid and stall_cnt to 0.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, occupancy = 0, stall_cnt = 0.
- Latency from accept to out_valid is 1 cycle.
- Throughput is 1 transfer/cycle while out_ready stays high.
- All outputs come from registers or decode of state only. There is no combinational in→out path.
- in_ready drops in the cycle after the block enters TWO. It returns in the cycle after a fire from TWO.
- Upstream must hold in_valid/in_data stable until accept. Downstream must hold out_ready independent of out_valid. Neither rule is checked.
- flush or rst mid-transfer takes effect at the next edge. Outputs show the reset values one cycle later.

## Structure
- Shared package `pipe_pkg`:
  - State typedef: EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2.
  - Occupancy width constant = 2.
- Sub-module `pipe_data_reg`: parametrised len-bit register with synchronous clear and active-high enable. Instantiated twice, for main and skid.
- Top level holds the FSM, the handshake decode and stall_cnt.

## Test plan
- Reset, then stream 0x1..0x8 with out_ready = 1 every cycle → out_data = 0x1..0x8 on consecutive cycles, first word 1 cycle after its accept. in_ready stays 1. stall_cnt = 0.
- Accept 0xA then 0xB with out_ready = 0 → occupancy = 2, in_ready = 0. Hold in_valid for 3 more cycles → stall_cnt = 3. Raise out_ready → out_data 0xA, then 0xB, with no loss.
- Drive random in_valid/out_ready for 10k cycles against a reference FIFO model → identical output sequence and occupancy never above 2.
- Fill to TWO, assert flush together with in_valid = 1 (0xC) → next cycle occupancy = 0, out_valid = 0, out_data = 0. 0xC is never output.
- Set cnt_len = 2 and back-pressure for 6 cycles → stall_cnt reaches 3 and holds at 3.
- Assert rst in state TWO with stall_cnt = 5 → next cycle all outputs at reset values. The first accept afterwards behaves as from EMPTY.
